prescale_scheduler: RTL and testbench

Shares one free-running prescaler (divide-by-(PRESCALE+1) chain) between NCH independent timer channels. Each channel is programmed through a single write port with a reload count and a periodic or one-shot mode. Each channel produces a one-cycle tick pulse and a toggling square-wave output. The block replaces per-consumer divider instances in the lab top level, so the LED, debounce and display-scan logic all draw timing from one divider.

---
 rtl/prescale_scheduler.sv | 163 ++++++++++++++++
 tb/tb_prescale_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prescale_scheduler.sv
// prescale_scheduler: one shared divide-by-(PRESCALE+1) prescaler feeding NCH timers.
// Define PRESCALER_RESYNC_EN to zero the prescaler on every accepted start.
module prescale_scheduler #(
  parameter int PRESCALE = 71,
  parameter int NCH      = 4,
  parameter int CW       = 16
) (
  input  logic                   cin,
  input  logic                   rst,
  input  logic                   wr_en,
  output logic                   wr_ready,
  input  logic [1:0]             wr_op,
  input  logic [$clog2(NCH)-1:0] wr_ch,
  input  logic [CW-1:0]          wr_data,
  input  logic                   wr_mode,
  output logic [NCH-1:0]         tick,
  output logic [NCH-1:0]         cout,
  output logic [NCH-1:0]         busy,
  output logic [NCH-1:0]         done,
  output logic                   err
);

  localparam int AW = $clog2(NCH);
  localparam int PW = (PRESCALE < 1) ? 1 : $clog2(PRESCALE + 1);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_START = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q [NCH];
  state_t          state_d [NCH];
  logic [CW-1:0]   cnt_q   [NCH];
  logic [CW-1:0]   cnt_d   [NCH];
  logic [CW-1:0]   rld_q   [NCH];
  logic [CW-1:0]   rld_d   [NCH];
  logic [NCH-1:0]  mode_q, mode_d;
  logic [NCH-1:0]  ld_q, ld_d;
  logic [NCH-1:0]  tick_d, cout_d, done_d;
  logic [NCH-1:0]  hit;
  logic            err_d;
  logic [PW-1:0]   pcount;
  logic            pre_tick;
  logic            acc;
  logic            resync;

  assign pre_tick = (pcount == PW'(PRESCALE));
  assign acc      = wr_en && wr_ready;

`ifdef PRESCALER_RESYNC_EN
  assign resync = acc && (wr_op == OP_START);
`else
  assign resync = 1'b0;
`endif

  always_ff @(posedge cin) begin
    if (rst) begin
      pcount <= '0;
    end else if (resync || pre_tick) begin
      pcount <= '0;
    end else begin
      pcount <= pcount + PW'(1);
    end
  end

  // A channel addressed by the current write ignores this cycle's pre_tick.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      hit[c] = acc && (wr_op != OP_NOP) && (wr_ch == AW'(c));
    end
  end

  always_comb begin
    err_d = err;
    for (int c = 0; c < NCH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      rld_d[c]   = rld_q[c];
      mode_d[c]  = mode_q[c];
      ld_d[c]    = ld_q[c];
      tick_d[c]  = 1'b0;
      cout_d[c]  = cout[c];
      done_d[c]  = done[c];
      if (hit[c]) begin
        case (wr_op)
          OP_LOAD: begin
            if (wr_data == '0) begin
              err_d = 1'b1;
            end else begin
              rld_d[c]  = wr_data;
              mode_d[c] = wr_mode;
              ld_d[c]   = 1'b1;
              done_d[c] = 1'b0;
            end
          end
          OP_START: begin
            if (ld_q[c]) begin
              cnt_d[c]   = rld_q[c];
              state_d[c] = RUN;
              done_d[c]  = 1'b0;
            end else begin
              err_d = 1'b1;
            end
          end
          OP_STOP: state_d[c] = IDLE;
          default: ;
        endcase
      end else if (state_q[c] == RUN && pre_tick) begin
        if (cnt_q[c] == CW'(1)) begin
          tick_d[c] = 1'b1;
          cout_d[c] = ~cout[c];
          if (mode_q[c]) begin
            cnt_d[c] = rld_q[c];
          end else begin
            state_d[c] = IDLE;
            done_d[c]  = 1'b1;
          end
        end else begin
          cnt_d[c] = cnt_q[c] - CW'(1);
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      busy[c] = (state_q[c] == RUN);
    end
  end

  always_ff @(posedge cin) begin
    if (rst) begin
      wr_ready <= 1'b0;
      tick     <= '0;
      cout     <= '0;
      done     <= '0;
      err      <= 1'b0;
      mode_q   <= '0;
      ld_q     <= '0;
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= IDLE;
        cnt_q[c]   <= '0;
        rld_q[c]   <= '0;
      end
    end else begin
      wr_ready <= !acc;
      tick     <= tick_d;
      cout     <= cout_d;
      done     <= done_d;
      err      <= err_d;
      mode_q   <= mode_d;
      ld_q     <= ld_d;
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        rld_q[c]   <= rld_d[c];
      end
    end
  end

endmodule

// File: tb/tb_prescale_scheduler.sv
// tb_prescale_scheduler: directed checks of the shared-prescaler timer block.
// Runs with PRESCALE=3 so every timer period is a multiple of 4 cycles.
module tb_prescale_scheduler;

  localparam int P = 3;
  localparam int N = 4;
  localparam int W = 16;

  localparam logic [1:0] NOP   = 2'b00;
  localparam logic [1:0] LOAD  = 2'b01;
  localparam logic [1:0] START = 2'b10;
  localparam logic [1:0] STOP  = 2'b11;

  logic          cin = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          wr_ready;
  logic [1:0]    wr_op = 2'b00;
  logic [1:0]    wr_ch = 2'b00;
  logic [W-1:0]  wr_data = '0;
  logic          wr_mode = 1'b0;
  logic [N-1:0]  tick, cout, busy, done;
  logic          err;

  prescale_scheduler #(.PRESCALE(P), .NCH(N), .CW(W)) dut (
    .cin(cin), .rst(rst), .wr_en(wr_en), .wr_ready(wr_ready),
    .wr_op(wr_op), .wr_ch(wr_ch), .wr_data(wr_data), .wr_mode(wr_mode),
    .tick(tick), .cout(cout), .busy(busy), .done(done), .err(err)
  );

  always #5 cin = ~cin;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int pbase  = 0;
  int coutbad = 0;
  bit mon_en = 1'b0;
  logic [N-1:0] cprev;
  int tq [N][$];

  // cyc is the index of the current cycle; cycle 0 follows the last reset edge.
  always @(posedge cin) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge cin) begin
    for (int c = 0; c < N; c++) begin
      if (tick[c] === 1'b1) tq[c].push_back(cyc);
      if (mon_en && ((cout[c] != cprev[c]) != tick[c])) coutbad++;
    end
    cprev = cout;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge cin);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) cyc1();
  endtask

  task automatic wr(input logic [1:0] op, input int ch, input int data,
                    input logic mode, output int tacc);
    int k;
    k = 0;
    while (!wr_ready && k < 20) begin
      cyc1();
      k++;
    end
    chk("wr_ready_wait", int'(wr_ready), 1);
    wr_en   = 1'b1;
    wr_op   = op;
    wr_ch   = 2'(ch);
    wr_data = W'(data);
    wr_mode = mode;
    tacc    = cyc;
`ifdef PRESCALER_RESYNC_EN
    if (op == START) pbase = cyc + 1;
`endif
    cyc1();
    wr_en = 1'b0;
    wr_op = NOP;
  endtask

  // Cycle in which tick rises for a channel started in cycle t with reload r.
  function automatic int firsttick(input int t, input int r);
    int p;
    p = t + 1;
    while (((p - pbase) % 4) != 3) p++;
    return p + 4 * (r - 1) + 1;
  endfunction

  typedef struct {
    logic [1:0] op;
    int         ch;
    int         data;
    logic       mode;
    logic [3:0] busy;
    logic [3:0] done;
    logic       err;
  } vec_t;

  vec_t tv [10];

  initial begin
    int t, ft, e2, bz, bad, cv, k;

    tv[0] = '{STOP,  0, 0, 1'b0, 4'b0000, 4'b0010, 1'b0};
    tv[1] = '{LOAD,  3, 5, 1'b1, 4'b0000, 4'b0010, 1'b0};
    tv[2] = '{START, 3, 0, 1'b0, 4'b1000, 4'b0010, 1'b0};
    tv[3] = '{START, 1, 0, 1'b0, 4'b1010, 4'b0000, 1'b0};
    tv[4] = '{LOAD,  1, 4, 1'b1, 4'b1010, 4'b0000, 1'b0};
    tv[5] = '{STOP,  3, 0, 1'b0, 4'b0010, 4'b0000, 1'b0};
    tv[6] = '{STOP,  1, 0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tv[7] = '{NOP,   2, 9, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tv[8] = '{START, 2, 0, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tv[9] = '{LOAD,  3, 7, 1'b0, 4'b0000, 4'b0000, 1'b1};

    // reset
    cyc1();
    cyc1();
    chk("rst_tick", int'(tick), 0);
    chk("rst_cout", int'(cout), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_wr_ready", int'(wr_ready), 0);
    rst = 1'b0;
    cyc1();
    chk("wr_ready_after_rst", int'(wr_ready), 1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (int'(dut.pcount) != cyc % 4) bad++;
      cyc1();
    end
    chk("pcount_wrap", bad, 0);
    mon_en = 1'b1;

    // ch0 periodic, reload 2
    wr(LOAD, 0, 2, 1'b1, t);
    tq[0].delete();
    wr(START, 0, 0, 1'b0, t);
    ft = firsttick(t, 2);
    bz = 0;
    while (cyc < ft + 34) begin
      if (!busy[0]) bz++;
      cyc1();
    end
    chk("t1_busy0", bz, 0);
    chk("t1_count", tq[0].size(), 5);
    if (tq[0].size() > 0) chk("t1_first", tq[0][0], ft);
    bad = 0;
    for (int i = 1; i < tq[0].size(); i++)
      if (tq[0][i] - tq[0][i-1] != 8) bad++;
    chk("t1_period", bad, 0);
    chk("t1_cout_toggle", coutbad, 0);

    // ch1 one-shot, reload 3
    wr(LOAD, 1, 3, 1'b0, t);
    tq[1].delete();
    wr(START, 1, 0, 1'b0, t);
    ft = firsttick(t, 3);
    run_to(ft + 2);
    chk("t2_count", tq[1].size(), 1);
    if (tq[1].size() > 0) chk("t2_when", tq[1][0], ft);
    chk("t2_busy1", int'(busy[1]), 0);
    chk("t2_done1", int'(done[1]), 1);
    run_to(cyc + 50);
    chk("t2_no_more", tq[1].size(), 1);

    // stop ch0 mid-period, then restart
    k = 0;
    while (!tick[0] && k < 20) begin
      cyc1();
      k++;
    end
    cyc1();
    cyc1();
    cyc1();
    wr(STOP, 0, 0, 1'b0, t);
    tq[0].delete();
    cv = int'(cout[0]);
    run_to(cyc + 30);
    chk("t3_no_tick", tq[0].size(), 0);
    chk("t3_cout_frozen", int'(cout[0]), cv);
    chk("t3_busy0", int'(busy[0]), 0);
    wr(START, 0, 0, 1'b0, t);
    ft = firsttick(t, 2);
    run_to(ft + 10);
    chk("t3_count", tq[0].size(), 2);
    if (tq[0].size() == 2) begin
      chk("t3_first", tq[0][0], ft);
      chk("t3_second", tq[0][1], ft + 8);
    end

    // write handshake
    wr(NOP, 0, 0, 1'b0, t);
    chk("hs_low", int'(wr_ready), 0);
    cyc1();
    chk("hs_high", int'(wr_ready), 1);

    for (int i = 0; i < 10; i++) begin
      wr(tv[i].op, tv[i].ch, tv[i].data, tv[i].mode, t);
      chk($sformatf("v%0d_busy", i), int'(busy), int'(tv[i].busy));
      chk($sformatf("v%0d_done", i), int'(done), int'(tv[i].done));
      chk($sformatf("v%0d_err", i), int'(err), int'(tv[i].err));
    end

    // start ch0 in the pre_tick cycle of its second expiry
    wr(LOAD, 0, 2, 1'b1, t);
    tq[0].delete();
    wr(START, 0, 0, 1'b0, t);
    ft = firsttick(t, 2);
    e2 = ft - 1 + 8;
    run_to(e2);
    wr(START, 0, 0, 1'b0, t);
    chk("t5_acc_cycle", t, e2);
    run_to(e2 + 12);
    chk("t5_count", tq[0].size(), 2);
    if (tq[0].size() == 2) begin
      chk("t5_first", tq[0][0], ft);
      chk("t5_restart", tq[0][1], e2 + 9);
    end
    chk("t5_cout_toggle", coutbad, 0);

    // reset while ch0 and ch1 run
    wr(LOAD, 1, 3, 1'b1, t);
    wr(START, 1, 0, 1'b0, t);
    run_to(cyc + 5);
    chk("t6_running", int'(busy[1:0]), 3);
    mon_en = 1'b0;
    rst = 1'b1;
    pbase = 0;
    cyc1();
    chk("t6_tick", int'(tick), 0);
    chk("t6_cout", int'(cout), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_err", int'(err), 0);
    chk("t6_wr_ready", int'(wr_ready), 0);
    chk("t6_pcount", int'(dut.pcount), 0);
    rst = 1'b0;
    cyc1();
    chk("t6_ready_back", int'(wr_ready), 1);

    // error cases
    wr(LOAD, 2, 0, 1'b1, t);
    chk("e_load0_err", int'(err), 1);
    wr(START, 2, 0, 1'b0, t);
    chk("e_load0_idle", int'(busy[2]), 0);
    wr(START, 3, 0, 1'b0, t);
    chk("e_unl_err", int'(err), 1);
    chk("e_unl_busy", int'(busy[3]), 0);
    rst = 1'b1;
    cyc1();
    rst = 1'b0;
    cyc1();
    wr(START, 3, 0, 1'b0, t);
    chk("e_unl_only_err", int'(err), 1);
    chk("e_unl_only_busy", int'(busy[3]), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
